// File: rtl/wave_pac.sv
// Phase-accumulator waveform generator: sine/square/triangle/sawtooth, 8-bit unsigned output.
// Optional WAVE_PAC_SYNC_EN adds a sync input that restarts the accumulator at phase zero.
module wave_pac #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
`ifdef WAVE_PAC_SYNC_EN
  input  logic               sync,
`endif
  input  logic [PHASE_W-1:0] fword,
  input  logic [PHASE_W-1:0] poff,
  input  logic [1:0]         mode,
  output logic [7:0]         amplitude,
  output logic               valid
);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_e;

  logic [PHASE_W-1:0] acc_q, acc_d, acc_base;
  logic [7:0]         p8_d;
  logic [7:0]         p8_p1_q;
  logic [1:0]         mode_p1_q;
  logic               vld_p1_q;
  logic [7:0]         amp_d;
  logic [7:0]         amp_p2_q;
  logic               vld_p2_q;

  function automatic logic [7:0] sine_quarter(input logic [5:0] idx);
    logic [7:0] v;
    case (idx)
      6'd0:  v = 8'h80;  6'd1:  v = 8'h83;  6'd2:  v = 8'h86;  6'd3:  v = 8'h89;
      6'd4:  v = 8'h8C;  6'd5:  v = 8'h90;  6'd6:  v = 8'h93;  6'd7:  v = 8'h96;
      6'd8:  v = 8'h99;  6'd9:  v = 8'h9C;  6'd10: v = 8'h9F;  6'd11: v = 8'hA2;
      6'd12: v = 8'hA5;  6'd13: v = 8'hA8;  6'd14: v = 8'hAB;  6'd15: v = 8'hAE;
      6'd16: v = 8'hB1;  6'd17: v = 8'hB3;  6'd18: v = 8'hB6;  6'd19: v = 8'hB9;
      6'd20: v = 8'hBC;  6'd21: v = 8'hBF;  6'd22: v = 8'hC1;  6'd23: v = 8'hC4;
      6'd24: v = 8'hC7;  6'd25: v = 8'hC9;  6'd26: v = 8'hCC;  6'd27: v = 8'hCE;
      6'd28: v = 8'hD1;  6'd29: v = 8'hD3;  6'd30: v = 8'hD5;  6'd31: v = 8'hD8;
      6'd32: v = 8'hDA;  6'd33: v = 8'hDC;  6'd34: v = 8'hDE;  6'd35: v = 8'hE0;
      6'd36: v = 8'hE2;  6'd37: v = 8'hE4;  6'd38: v = 8'hE6;  6'd39: v = 8'hE8;
      6'd40: v = 8'hEA;  6'd41: v = 8'hEB;  6'd42: v = 8'hED;  6'd43: v = 8'hEF;
      6'd44: v = 8'hF0;  6'd45: v = 8'hF1;  6'd46: v = 8'hF3;  6'd47: v = 8'hF4;
      6'd48: v = 8'hF5;  6'd49: v = 8'hF6;  6'd50: v = 8'hF8;  6'd51: v = 8'hF9;
      6'd52: v = 8'hFA;  6'd53: v = 8'hFA;  6'd54: v = 8'hFB;  6'd55: v = 8'hFC;
      6'd56: v = 8'hFD;  6'd57: v = 8'hFD;  6'd58: v = 8'hFE;  6'd59: v = 8'hFE;
      6'd60: v = 8'hFE;
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  // Second quarter mirrors the first; its start (low bits zero) folds onto the peak entry.
  function automatic logic [7:0] sine_lookup(input logic [7:0] p);
    logic [5:0] q;
    logic [7:0] v;
    if (!p[6])
      q = p[5:0];
    else if (p[5:0] != 6'd0)
      q = ~p[5:0] + 6'd1;
    else
      q = 6'd63;
    v = sine_quarter(q);
    return p[7] ? ~v : v;
  endfunction

  function automatic logic [7:0] wave_shape(input logic [7:0] p, input logic [1:0] m);
    logic [7:0] t;
    logic [7:0] r;
    t = {p[6:0], 1'b0};
    case (mode_e'(m))
      MODE_SINE:   r = sine_lookup(p);
      MODE_SQUARE: r = p[7] ? 8'h00 : 8'hFF;
      MODE_TRI:    r = p[7] ? ~t : t;
      default:     r = p;
    endcase
    return r;
  endfunction

  always_comb begin
    acc_base = acc_q;
`ifdef WAVE_PAC_SYNC_EN
    if (sync) acc_base = '0;
`endif
    acc_d = en ? acc_base + fword : acc_base;
    p8_d  = 8'((acc_base + poff) >> (PHASE_W - 8));
    amp_d = wave_shape(p8_p1_q, mode_p1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Stage 1: lookup phase and mode captured together on each sampled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p8_p1_q   <= 8'h00;
      mode_p1_q <= 2'd0;
      vld_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= en;
      if (en) begin
        p8_p1_q   <= p8_d;
        mode_p1_q <= mode;
      end
    end
  end

  // Stage 2: waveform value; amplitude holds through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp_p2_q <= 8'h00;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) amp_p2_q <= amp_d;
    end
  end

  assign amplitude = amp_p2_q;
  assign valid     = vld_p2_q;

endmodule

// File: tb/tb_wave_pac.sv
// Directed bench for wave_pac: table of waveform vectors plus hand-written pipeline sequences.
module tb_wave_pac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en8;
  logic [7:0]  fw8, po8;
  logic [1:0]  md8;
  logic [7:0]  amp8;
  logic        vld8;
  logic        en16;
  logic [15:0] fw16, po16;
  logic [1:0]  md16;
  logic [7:0]  amp16;
  logic        vld16;
`ifdef WAVE_PAC_SYNC_EN
  logic        sync8, sync16;
`endif

  int n_pass  = 0;
  int n_total = 0;

  wave_pac #(.PHASE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8),
`ifdef WAVE_PAC_SYNC_EN
    .sync(sync8),
`endif
    .fword(fw8), .poff(po8), .mode(md8), .amplitude(amp8), .valid(vld8)
  );

  wave_pac #(.PHASE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16),
`ifdef WAVE_PAC_SYNC_EN
    .sync(sync16),
`endif
    .fword(fw16), .poff(po16), .mode(md16), .amplitude(amp16), .valid(vld16)
  );

  typedef struct {
    logic [1:0]      mode;
    logic [7:0]      fword;
    logic [7:0]      poff;
    logic [0:7][7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en8 = 1'b0; en16 = 1'b0;
    fw8 = '0; po8 = '0; md8 = '0;
    fw16 = '0; po16 = '0; md16 = '0;
`ifdef WAVE_PAC_SYNC_EN
    sync8 = 1'b0; sync16 = 1'b0;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int          ck_k   [12] = '{0, 1, 2, 3, 32, 64, 96, 128, 160, 192, 255, 256};
  logic [7:0]  ck_v   [12] = '{8'h80, 8'h83, 8'h86, 8'h89, 8'hDA, 8'hFF, 8'hDA,
                               8'h7F, 8'h25, 8'h00, 8'h7C, 8'h80};

  initial begin
    tbl[0] = '{mode: 2'd2, fword: 8'd32, poff: 8'h00,
               exp: {8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F}};
    tbl[1] = '{mode: 2'd1, fword: 8'd64, poff: 8'h00,
               exp: {8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00}};
    tbl[2] = '{mode: 2'd3, fword: 8'd32, poff: 8'h00,
               exp: {8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0}};
    tbl[3] = '{mode: 2'd3, fword: 8'd32, poff: 8'h80,
               exp: {8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h00, 8'h20, 8'h40, 8'h60}};
    tbl[4] = '{mode: 2'd0, fword: 8'd32, poff: 8'h00,
               exp: {8'h80, 8'hDA, 8'hFF, 8'hDA, 8'h7F, 8'h25, 8'h00, 8'h25}};
    tbl[5] = '{mode: 2'd0, fword: 8'd16, poff: 8'h00,
               exp: {8'h80, 8'hB1, 8'hDA, 8'hF5, 8'hFF, 8'hF5, 8'hDA, 8'hB1}};
    tbl[6] = '{mode: 2'd0, fword: 8'd8, poff: 8'h04,
               exp: {8'h8C, 8'hA5, 8'hBC, 8'hD1, 8'hE2, 8'hF0, 8'hFA, 8'hFE}};
    tbl[7] = '{mode: 2'd0, fword: 8'd8, poff: 8'hC4,
               exp: {8'h01, 8'h05, 8'h0F, 8'h1D, 8'h2E, 8'h43, 8'h5A, 8'h73}};
    tbl[8] = '{mode: 2'd0, fword: 8'd0, poff: 8'h20,
               exp: {8'hDA, 8'hDA, 8'hDA, 8'hDA, 8'hDA, 8'hDA, 8'hDA, 8'hDA}};
    tbl[9] = '{mode: 2'd2, fword: 8'd16, poff: 8'h08,
               exp: {8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0}};

    // Reset state, asserted before any clock edge.
    en8 = 1'b0; en16 = 1'b0;
    fw8 = '0; po8 = '0; md8 = '0;
    fw16 = '0; po16 = '0; md16 = '0;
`ifdef WAVE_PAC_SYNC_EN
    sync8 = 1'b0; sync16 = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    chk("reset_amp8", amp8, 8'h00);
    chk("reset_vld8", {7'd0, vld8}, 8'd1 - 8'd1);
    chk("reset_amp16", amp16, 8'h00);
    chk("reset_vld16", {7'd0, vld16}, 8'h00);

    // Table of waveform vectors, continuous en from reset.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      md8 = tbl[i].mode; fw8 = tbl[i].fword; po8 = tbl[i].poff; en8 = 1'b1;
      step();
      chk($sformatf("tbl%0d_first_vld", i), {7'd0, vld8}, 8'h00);
      for (int k = 0; k < 8; k++) begin
        step();
        chk($sformatf("tbl%0d_amp%0d", i, k), amp8, tbl[i].exp[k]);
        chk($sformatf("tbl%0d_vld%0d", i, k), {7'd0, vld8}, 8'h01);
      end
    end

    // Slow sine sweep through a full cycle and past wrap.
    do_reset();
    md8 = 2'd0; fw8 = 8'd1; po8 = 8'h00; en8 = 1'b1;
    step();
    chk("sine1_first_vld", {7'd0, vld8}, 8'h00);
    begin
      int c;
      c = 0;
      for (int k = 0; k <= 256; k++) begin
        step();
        if (c < 12 && k == ck_k[c]) begin
          chk($sformatf("sine1_s%0d", k), amp8, ck_v[c]);
          chk($sformatf("sine1_v%0d", k), {7'd0, vld8}, 8'h01);
          c++;
        end
      end
    end

    // en bubbles: valid follows en two edges later, amplitude held.
    do_reset();
    md8 = 2'd1; fw8 = 8'd128; en8 = 1'b1;
    step();
    chk("bub_v0", {7'd0, vld8}, 8'h00);
    en8 = 1'b0;
    step();
    chk("bub_v1", {7'd0, vld8}, 8'h01);
    chk("bub_a1", amp8, 8'hFF);
    en8 = 1'b1;
    step();
    chk("bub_v2", {7'd0, vld8}, 8'h00);
    chk("bub_a2", amp8, 8'hFF);
    en8 = 1'b0;
    step();
    chk("bub_v3", {7'd0, vld8}, 8'h01);
    chk("bub_a3", amp8, 8'h00);
    step();
    chk("bub_v4", {7'd0, vld8}, 8'h00);
    chk("bub_a4", amp8, 8'h00);

    // Wide accumulator: sawtooth wrap near 0xFFFF, with and without half-cycle offset.
    for (int r = 0; r < 2; r++) begin
      logic [7:0] base;
      base = (r == 0) ? 8'h00 : 8'h80;
      do_reset();
      md16 = 2'd3; po16 = (r == 0) ? 16'h0000 : 16'h8000;
      fw16 = 16'hFFF0; en16 = 1'b1;
      step();
      fw16 = 16'h0100;
      step();
      chk($sformatf("wrap%0d_s0", r), amp16, base);
      step();
      chk($sformatf("wrap%0d_s1", r), amp16, base + 8'hFF);
      step();
      chk($sformatf("wrap%0d_s2", r), amp16, base);
      step();
      chk($sformatf("wrap%0d_s3", r), amp16, base + 8'h01);
      chk($sformatf("wrap%0d_vld", r), {7'd0, vld16}, 8'h01);
      step();
      chk($sformatf("wrap%0d_s4", r), amp16, base + 8'h02);
    end

    // Mode switch mid-stream.
    do_reset();
    md8 = 2'd0; fw8 = 8'd16; en8 = 1'b1;
    step();
    step();
    chk("msw_s0", amp8, 8'h80);
    md8 = 2'd3;
    step();
    chk("msw_s1", amp8, 8'hB1);
    step();
    chk("msw_s2", amp8, 8'h20);
    step();
    chk("msw_s3", amp8, 8'h30);

    // Reset mid-stream clears outputs immediately and restarts from acc=0.
    do_reset();
    md8 = 2'd0; fw8 = 8'd16; en8 = 1'b1;
    step();
    step();
    step();
    chk("mrst_pre", amp8, 8'hB1);
    rst_n = 1'b0;
    #2;
    chk("mrst_amp", amp8, 8'h00);
    chk("mrst_vld", {7'd0, vld8}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_v0", {7'd0, vld8}, 8'h00);
    step();
    chk("mrst_s0", amp8, 8'h80);
    chk("mrst_v1", {7'd0, vld8}, 8'h01);
    step();
    chk("mrst_s1", amp8, 8'hB1);

`ifdef WAVE_PAC_SYNC_EN
    do_reset();
    md8 = 2'd0; fw8 = 8'd16; en8 = 1'b1;
    step();
    step();
    step();
    sync8 = 1'b1;
    step();
    chk("sync_s_pre", amp8, 8'hDA);
    sync8 = 1'b0;
    step();
    chk("sync_s0", amp8, 8'h80);
    step();
    chk("sync_s1", amp8, 8'hB1);
    sync8 = 1'b1; en8 = 1'b0;
    step();
    chk("sync_s2", amp8, 8'hDA);
    sync8 = 1'b0; en8 = 1'b1;
    step();
    chk("sync_bub_v", {7'd0, vld8}, 8'h00);
    chk("sync_bub_a", amp8, 8'hDA);
    step();
    chk("sync_z0", amp8, 8'h80);
    chk("sync_z0v", {7'd0, vld8}, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wave_pac.md
WAVE_PAC -- requirements
Module: wave_pac

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, accumulator and tuning-word width, legal range 8..24.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port en  input  1  sample strobe; one output sample per cycle with en=1.
REQ-005 SHALL have port fword  input  PHASE_W  tuning word added to accumulator per sample.
REQ-006 SHALL have port poff  input  PHASE_W  phase offset applied to lookup, not to accumulator.
REQ-007 SHALL have port mode  input  2  waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-008 SHALL have port amplitude  output  8  unsigned sample, 0x80 = midscale.
REQ-009 SHALL have port valid  output  1  amplitude holds a new sample this cycle.

Function
REQ-010 SHALL keep accumulator acc (PHASE_W bits); on edge with en=1, acc <= acc + fword, modulo 2^PHASE_W, carry discarded.
REQ-011 SHALL form lookup phase p8 = top 8 bits of (acc + poff) mod 2^PHASE_W, using acc before that edge's increment.
REQ-012 SHALL be 2-stage pipeline: stage 1 registers p8, mode, en-valid; stage 2 registers amplitude and valid.
REQ-013 SHALL assert valid exactly 2 edges after an edge sampling en=1; en=0 produces bubble, amplitude holds last value.
REQ-014 SHALL sample mode alongside phase in stage 1, so a mode change affects only samples taken on/after the change edge.
REQ-015 Sine: quarter-wave index q = p8[5:0] when p8[6]=0; q = 64 - p8[5:0] when p8[6]=1 and p8[5:0]!=0; q = 63 when p8[6]=1 and p8[5:0]=0.
REQ-016 Sine: value = team standard 64-entry quarter-wave table (index 0 = 0x80, 1 = 0x83, 32 = 0xDA, 61..63 = 0xFF); amplitude = value when p8[7]=0, bitwise ~value when p8[7]=1.
REQ-017 Square: amplitude = 0xFF when p8[7]=0, 0x00 when p8[7]=1.
REQ-018 Triangle: t = {p8[6:0],1'b0}; amplitude = t when p8[7]=0, ~t when p8[7]=1.
REQ-019 Sawtooth: amplitude = p8.
REQ-020 fword=0 SHALL hold phase constant; valid still pulses per en.

Reset
REQ-021 rst_n low SHALL asynchronously clear acc, all stage registers, amplitude=0x00, valid=0.
REQ-022 Reset mid-stream SHALL discard in-flight samples; first valid after release is 2 edges after first en=1 edge, computed from acc=0.

Configuration
REQ-023 Macro WAVE_PAC_SYNC_EN defined: SHALL add input sync (1 bit); edge with sync=1 loads acc <= fword if en=1 (stage 1 captures phase of acc=0 plus poff) or acc <= 0 if en=0; sync overrides normal increment.
REQ-024 Macro WAVE_PAC_SYNC_EN undefined: sync port SHALL be absent; accumulator restarts only via rst_n.

Verification
REQ-025 PHASE_W=8, poff=0, mode=0, fword=1, en=1 continuous from reset -> amplitude 0x80,0x83,0x86,...; sample 64 = 0xFF; sample 128 = 0x7F; first valid 2 edges after first en edge.
REQ-026 PHASE_W=8, mode=2, fword=32 -> 0x00,0x40,0x80,0xC0,0xFF,0xBF,0x7F,0x3F, repeating.
REQ-027 PHASE_W=8, mode=1, fword=64 -> 0xFF,0xFF,0x00,0x00, repeating; en toggled 1,0,1 -> valid 1,0,1 delayed 2 edges, amplitude held on bubble.
REQ-028 PHASE_W=16, mode=3, acc near 0xFFFF, fword=0x0100 -> sawtooth wraps 0xFF to 0x00 with no glitch; poff=0x8000 shifts output by 0x80.
REQ-029 Mode switched 0->3 mid-stream -> first sawtooth sample appears exactly 2 edges after switch edge, no mixed samples.
REQ-030 rst_n pulsed low mid-stream -> amplitude=0x00, valid=0 immediately; with WAVE_PAC_SYNC_EN, sync=1,en=1 -> next valid sample equals phase-0 value (sine 0x80).
